// File: rtl/gtech_qual_pkg.sv
// Shared types and constants for the GTECH 2-input cell qualification harness.
// Holds the exerciser FSM state encoding and reference truth tables indexed by {A,B}.
package gtech_qual_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit 3 is the expected Z for A=1,B=1; bit 0 for A=0,B=0.
    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

    localparam int ERR_W = 8;

endpackage

// File: rtl/gtech_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Clear has priority over increment.
module gtech_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/gtech_cell2_exerciser.sv
// Drives a 2-input combinational cell through all {A,B} vectors for ITERATIONS sweeps,
// samples Z after SETTLE cycles and counts mismatches against TRUTH.
module gtech_cell2_exerciser
    import gtech_qual_pkg::*;
#(
    parameter logic [3:0] TRUTH      = TRUTH_AND2,
    parameter int         ITERATIONS = 16,
    parameter int         SETTLE     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             cell_a,
    output logic             cell_b,
    input  logic             cell_z,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_vec
);

    localparam logic [9:0] LAST_SWEEP  = 10'(ITERATIONS - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             w_accept;
    logic             w_sample;
    logic             w_mismatch;
    logic [1:0]       r_vec;
    logic [9:0]       r_sweep;
    logic [3:0]       r_settle_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_ff_valid;
    logic [1:0]       r_ff_vec;
    logic [ERR_W-1:0] w_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_SETTLE;
                    w_accept     = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == 4'd0) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if ((r_vec == 2'b11) && (r_sweep == LAST_SWEEP)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_sample   = (r_state == ST_SAMPLE);
    assign w_mismatch = w_sample && (cell_z != TRUTH[r_vec]);

    // Vector, sweep and settle counters; the vector register is the cell drive itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec        <= 2'b00;
            r_sweep      <= '0;
            r_settle_cnt <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_vec     <= 2'b00;
        end else if (w_accept) begin
            r_vec        <= 2'b00;
            r_sweep      <= '0;
            r_settle_cnt <= SETTLE_LOAD;
            r_ff_valid   <= 1'b0;
            r_ff_vec     <= 2'b00;
        end else if (w_sample) begin
            if (w_mismatch && !r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_vec   <= r_vec;
            end
            if (w_state_next == ST_SETTLE) begin
                r_vec        <= r_vec + 2'd1;
                r_settle_cnt <= SETTLE_LOAD;
                if (r_vec == 2'b11) begin
                    r_sweep <= r_sweep + 10'd1;
                end
            end
        end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 4'd0)) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end

    // The final sample's mismatch is folded in directly so pass lands with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);
            r_done <= (w_state_next == ST_DONE);
            if (w_state_next != ST_DONE) begin
                r_pass <= 1'b0;
            end else if (r_state == ST_SAMPLE) begin
                r_pass <= (w_err_count == '0) && !w_mismatch;
            end
        end
    end

    gtech_sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_inc (w_mismatch),
        .o_q   (w_err_count)
    );

    assign cell_a           = r_vec[1];
    assign cell_b           = r_vec[0];
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = w_err_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;

endmodule
